// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: shift-function encodings and
// the width-independent part of the per-stage record.
package shift_pkg;

    typedef logic [1:0] sf_t;

    localparam sf_t SF_SLL = 2'b00;
    localparam sf_t SF_SRL = 2'b01;
    localparam sf_t SF_ROR = 2'b10;
    localparam sf_t SF_SRA = 2'b11;

    // Data, remaining distance and tag are width-parametrised, so they travel
    // beside this record in each stage rather than inside it.
    typedef struct packed {
        logic valid;
        sf_t  sf;
        logic sign;
    } stage_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage: conditionally shifts by STEP according to the
// distance bit log2(STEP), then registers the operation for the next stage.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 5,
    parameter int TAGW  = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  stage_ctl_t       i_ctl,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SW-1:0]    i_dist,
    input  logic [TAGW-1:0]  i_tag,
    input  logic             i_ready,
    output logic             o_ready,
    output stage_ctl_t       o_ctl,
    output logic [WIDTH-1:0] o_data,
    output logic [SW-1:0]    o_dist,
    output logic [TAGW-1:0]  o_tag
);

    localparam int K = $clog2(STEP);

    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_dist;
    logic [TAGW-1:0]  r_tag;
    logic [WIDTH-1:0] w_shifted;

    // NOTE: default assignment first, so every path assigns w_shifted and no latch is inferred.
    always_comb begin
        w_shifted = i_data;
        if (i_dist[K]) begin
            case (i_ctl.sf)
                SF_SLL: w_shifted = i_data << STEP;
                SF_SRL: w_shifted = i_data >> STEP;
                SF_SRA: w_shifted = {{STEP{i_ctl.sign}}, i_data[WIDTH-1:STEP]};
                SF_ROR: w_shifted = {i_data[STEP-1:0], i_data[WIDTH-1:STEP]};
            endcase
        end
    end

    // A stage accepts whenever it is empty or its contents move on this edge.
    assign o_ready = ~r_ctl.valid | i_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: data registers are reset too, so sres/zero leave reset at 0/1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= '0;
            r_data <= '0;
            r_dist <= '0;
            r_tag  <= '0;
        end else if (i_flush) begin
            r_ctl.valid <= 1'b0;
        end else if (o_ready) begin
            r_ctl.valid <= i_ctl.valid;
            if (i_ctl.valid) begin
                r_ctl.sf   <= i_ctl.sf;
                r_ctl.sign <= i_ctl.sign;
                r_data     <= w_shifted;
                r_dist     <= i_dist;
                r_tag      <= i_tag;
            end
        end
    end

    assign o_ctl  = r_ctl;
    assign o_data = r_data;
    assign o_dist = r_dist;
    assign o_tag  = r_tag;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter: SW elastic stages, one distance bit each,
// valid/ready at both ends with bubble collapsing and a synchronous flush.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  TAGW  = 4,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    sdist,
    input  logic [1:0]       sf,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sres,
    output logic [TAGW-1:0]  out_tag,
    output logic             zero
);

    // Index k is the input side of stage k; index SW is the unit output.
    stage_ctl_t       w_ctl   [0:SW];
    logic [WIDTH-1:0] w_data  [0:SW];
    logic [SW-1:0]    w_dist  [0:SW];
    logic [TAGW-1:0]  w_tag   [0:SW];
    logic             w_ready [0:SW];

    assign w_ctl[0]    = '{valid: in_valid, sf: sf, sign: a[WIDTH-1]};
    assign w_data[0]   = a;
    assign w_dist[0]   = sdist;
    assign w_tag[0]    = in_tag;
    assign w_ready[SW] = out_ready;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .TAGW  (TAGW),
            .STEP  (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush),
            .i_ctl   (w_ctl[k]),
            .i_data  (w_data[k]),
            .i_dist  (w_dist[k]),
            .i_tag   (w_tag[k]),
            .i_ready (w_ready[k+1]),
            .o_ready (w_ready[k]),
            .o_ctl   (w_ctl[k+1]),
            .o_data  (w_data[k+1]),
            .o_dist  (w_dist[k+1]),
            .o_tag   (w_tag[k+1])
        );
    end

    // rst_n gates in_ready so nothing looks accepted while reset is held.
    assign in_ready  = w_ready[0] & ~flush & rst_n;
    assign out_valid = w_ctl[SW].valid;
    assign sres      = w_data[SW];
    assign out_tag   = w_tag[SW];
    assign zero      = (w_data[SW] == '0);

endmodule
